// File: rtl/conv_stream_ctrl.sv
// Conv pipeline controller: loads weights and im2col rows from memory,
// streams rows through the systolic array and writes the Y matrix back.
module conv_stream_ctrl #(
    parameter int                    M           = 12,
    parameter int                    N           = 9,
    parameter int                    K           = 5,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] WEIGHT_BASE = 32'h1000,
    parameter logic [ADDR_WIDTH-1:0] IM2COL_BASE = 32'h2000,
    parameter logic [ADDR_WIDTH-1:0] OUTPUT_BASE = 32'h3000,
    parameter int                    OUT_LAYOUT  = 0,
    parameter int                    RELU        = 0,
    parameter int                    SA_RST_CYC  = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    output logic                           err,
    output logic [ADDR_WIDTH-1:0]          addr_rd,
    input  logic [DATA_WIDTH-1:0]          data_rd,
    output logic [ADDR_WIDTH-1:0]          addr_wr,
    output logic [DATA_WIDTH-1:0]          data_wr,
    output logic                           mem_wr_en,
    output logic                           sa_rst,
    output logic [DATA_WIDTH*N-1:0]        X,
    output logic [DATA_WIDTH*N*K-1:0]      W,
    input  logic [DATA_WIDTH*K-1:0]        Y,
    input  logic                           Y_valid,
    input  logic                           sa_done
);

    localparam int DW  = DATA_WIDTH;
    localparam int AW  = ADDR_WIDTH;
    localparam int NK  = N * K;
    localparam int MN  = M * N;
    localparam int MK  = M * K;
    localparam int CW  = $clog2(NK + MN + SA_RST_CYC + 1);
    localparam int YCW = $clog2(M + 1);
    localparam int MW  = $clog2(M + 1);
    localparam int KW  = $clog2(K + 1);

    localparam logic [CW-1:0]  NK_C     = CW'(NK);
    localparam logic [CW-1:0]  MN_C     = CW'(MN);
    localparam logic [CW-1:0]  RST_LAST = CW'(SA_RST_CYC - 1);
    localparam logic [YCW-1:0] M_Y      = YCW'(M);
    localparam logic [MW-1:0]  M_LAST   = MW'(M - 1);
    localparam logic [KW-1:0]  K_LAST   = KW'(K - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_W, S_LOAD_X, S_SA_RST, S_STREAM, S_WRITE, S_DONE
    } state_e;

    state_e              state_q;
    logic [CW-1:0]       cnt_q;
    logic [YCW-1:0]      ycnt_q;
    logic [MW-1:0]       wm_q;
    logic [KW-1:0]       wk_q;
    logic [MN*DW-1:0]    xbuf_q;
    logic [MK*DW-1:0]    ybuf_q;
    logic                busy_q, done_q, err_q, wen_q, sa_rst_q;
    logic [AW-1:0]       addr_rd_q, addr_wr_q;
    logic [DW-1:0]       data_wr_q;
    logic [DW*N-1:0]     x_q;
    logic [DW*NK-1:0]    w_q;

    logic                take;
    logic [MK*DW-1:0]    ybuf_d;
    logic [YCW-1:0]      ycnt_d;
    logic [MW-1:0]       wm_d;
    logic [KW-1:0]       wk_d;

    // Y rows land in the buffer slot picked by the row counter; overflow rows drop
    always_comb begin
        take   = Y_valid && (ycnt_q < M_Y);
        ybuf_d = ybuf_q;
        for (int r = 0; r < M; r++) begin
            if (take && ycnt_q == YCW'(r)) begin
                ybuf_d[r*K*DW +: K*DW] = Y;
            end
        end
        ycnt_d = ycnt_q + YCW'(take);
        wk_d   = (wk_q == K_LAST) ? '0 : wk_q + 1'b1;
        wm_d   = (wk_q == K_LAST) ? wm_q + 1'b1 : wm_q;
    end

    function automatic logic [AW-1:0] waddr(input logic [MW-1:0] m,
                                            input logic [KW-1:0] k);
        if (OUT_LAYOUT != 0) begin
            return OUTPUT_BASE + AW'(m) * AW'(K) + AW'(k);
        end
        return OUTPUT_BASE + AW'(k) * AW'(M) + AW'(m);
    endfunction

    function automatic logic [DW-1:0] clamp(input logic [DW-1:0] v);
        return (RELU != 0 && v[DW-1]) ? '0 : v;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ycnt_q    <= '0;
            wm_q      <= '0;
            wk_q      <= '0;
            xbuf_q    <= '0;
            ybuf_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            wen_q     <= 1'b0;
            sa_rst_q  <= 1'b1;
            addr_rd_q <= '0;
            addr_wr_q <= '0;
            data_wr_q <= '0;
            x_q       <= '0;
            w_q       <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q   <= S_LOAD_W;
                        busy_q    <= 1'b1;
                        err_q     <= 1'b0;
                        cnt_q     <= '0;
                        ycnt_q    <= '0;
                        ybuf_q    <= '0;
                        addr_rd_q <= WEIGHT_BASE;
                    end
                end
                S_LOAD_W: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q < NK_C - 1'b1) addr_rd_q <= addr_rd_q + 1'b1;
                    if (cnt_q != '0) w_q <= {data_rd, w_q[NK*DW-1:DW]};
                    if (cnt_q == NK_C) begin
                        state_q   <= S_LOAD_X;
                        cnt_q     <= '0;
                        addr_rd_q <= IM2COL_BASE;
                    end
                end
                S_LOAD_X: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q < MN_C - 1'b1) addr_rd_q <= addr_rd_q + 1'b1;
                    if (cnt_q != '0) xbuf_q <= {data_rd, xbuf_q[MN*DW-1:DW]};
                    if (cnt_q == MN_C) begin
                        state_q   <= S_SA_RST;
                        cnt_q     <= '0;
                        addr_rd_q <= '0;
                    end
                end
                S_SA_RST: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == RST_LAST) begin
                        state_q  <= S_STREAM;
                        sa_rst_q <= 1'b0;
                        x_q      <= xbuf_q[N*DW-1:0];
                        xbuf_q   <= xbuf_q >> (N * DW);
                    end
                end
                S_STREAM: begin
                    // rows drain from the bottom; zeros shift in behind the last one
                    x_q    <= xbuf_q[N*DW-1:0];
                    xbuf_q <= xbuf_q >> (N * DW);
                    ybuf_q <= ybuf_d;
                    ycnt_q <= ycnt_d;
                    if (sa_done) begin
                        state_q   <= S_WRITE;
                        sa_rst_q  <= 1'b1;
                        x_q       <= '0;
                        err_q     <= (ycnt_d < M_Y);
                        wen_q     <= 1'b1;
                        wm_q      <= '0;
                        wk_q      <= '0;
                        addr_wr_q <= waddr('0, '0);
                        data_wr_q <= clamp(ybuf_d[DW-1:0]);
                        ybuf_q    <= ybuf_d >> DW;
                    end
                end
                S_WRITE: begin
                    if (wm_q == M_LAST && wk_q == K_LAST) begin
                        state_q <= S_DONE;
                        wen_q   <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        wm_q      <= wm_d;
                        wk_q      <= wk_d;
                        addr_wr_q <= waddr(wm_d, wk_d);
                        data_wr_q <= clamp(ybuf_q[DW-1:0]);
                        ybuf_q    <= ybuf_q >> DW;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign addr_rd   = addr_rd_q;
    assign addr_wr   = addr_wr_q;
    assign data_wr   = data_wr_q;
    assign mem_wr_en = wen_q;
    assign sa_rst    = sa_rst_q;
    assign X         = x_q;
    assign W         = w_q;

endmodule

// File: tb/tb_conv_stream_ctrl.sv
// Bench for conv_stream_ctrl: three layouts/ReLU variants in lockstep against
// a memory model, a behavioural systolic array and a golden convolution.
module tb_conv_stream_ctrl;

    localparam int M = 12;
    localparam int N = 9;
    localparam int K = 5;
    localparam int DW = 32;
    localparam int NK = N * K;
    localparam int MN = M * N;
    localparam int MK = M * K;
    localparam int LAT = 2;
    localparam logic [31:0] WB = 32'h1000;
    localparam logic [31:0] XB = 32'h2000;
    localparam logic [31:0] OB = 32'h3000;

    typedef struct {
        int wsel;
        int ny;
        int dat;
        bit glitch;
        bit xerr;
        int xdone;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy[3], done[3], err[3], wen[3], sar[3];
    logic [31:0] ard[3], awr[3], dwr[3];
    logic [DW*N-1:0] xo[3];
    logic [DW*NK-1:0] wo[3];
    logic [31:0] data_rd;
    logic [DW*K-1:0] Y;
    logic Y_valid;
    logic sa_done;

    int wts[NK];
    int img[MN];
    int ny = 12;
    int dat = 13;
    int run_id = 0;
    logic [DW*N-1:0] xr[M];
    int sc = 0;
    int xbad = 0;
    int dcnt = 0;
    int wrn[3];
    int oob[3];
    logic [31:0] om[3][MK];
    int tg[3][MK];
    int nerr = 0;
    int nchk = 0;
    vec_t tbl[6];

    always #5 clk = ~clk;

    for (genvar d = 0; d < 3; d++) begin : g_dut
        conv_stream_ctrl #(
            .OUT_LAYOUT(d == 1 ? 1 : 0),
            .RELU      (d == 2 ? 1 : 0)
        ) dut (
            .clk      (clk),
            .rst      (rst),
            .start    (start),
            .busy     (busy[d]),
            .done     (done[d]),
            .err      (err[d]),
            .addr_rd  (ard[d]),
            .data_rd  (data_rd),
            .addr_wr  (awr[d]),
            .data_wr  (dwr[d]),
            .mem_wr_en(wen[d]),
            .sa_rst   (sar[d]),
            .X        (xo[d]),
            .W        (wo[d]),
            .Y        (Y),
            .Y_valid  (Y_valid),
            .sa_done  (sa_done)
        );
    end

    function automatic logic [31:0] rdmem(input logic [31:0] a);
        if (a >= WB && a < WB + NK) return wts[int'(a - WB)];
        if (a >= XB && a < XB + MN) return img[int'(a - XB)];
        return 32'h0;
    endfunction

    function automatic logic [DW*K-1:0] ymodel(input logic [DW*N-1:0] xv);
        logic [DW*K-1:0] r;
        int acc;
        r = '0;
        for (int k = 0; k < K; k++) begin
            acc = 0;
            for (int n = 0; n < N; n++)
                acc += int'($signed(xv[n*DW +: DW])) * wts[n*K+k];
            r[k*DW +: DW] = 32'(acc);
        end
        return r;
    endfunction

    function automatic int gold(input int m, input int k, input int nyv);
        int acc;
        if (m >= nyv) return 0;
        acc = 0;
        for (int n = 0; n < N; n++) acc += img[m*N+n] * wts[n*K+k];
        return acc;
    endfunction

    always @(posedge clk) begin
        data_rd <= rdmem(ard[0]);
        for (int d = 0; d < 3; d++) begin
            if (wen[d] === 1'b1) begin
                wrn[d] <= wrn[d] + 1;
                if (awr[d] >= OB && awr[d] < OB + MK) begin
                    om[d][int'(awr[d] - OB)] <= dwr[d];
                    tg[d][int'(awr[d] - OB)] <= run_id;
                end else begin
                    oob[d] <= oob[d] + 1;
                end
            end
        end
        if (done[0] === 1'b1) dcnt <= dcnt + 1;
    end

    // behavioural array: Y row r appears LAT cycles after X row r
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            sc      <= 0;
            Y_valid <= 1'b0;
            sa_done <= 1'b0;
            Y       <= '0;
        end else if (sar[0]) begin
            sc      <= 0;
            Y_valid <= 1'b0;
            sa_done <= 1'b0;
        end else begin
            if (sc < M) xr[sc] <= xo[0];
            else if (xo[0] != '0) xbad <= xbad + 1;
            sc      <= sc + 1;
            Y_valid <= (sc + 1 >= LAT) && (sc + 1 - LAT < ny);
            Y       <= (sc + 1 >= LAT) ? ymodel(xr[(sc + 1 - LAT) % M]) : '0;
            sa_done <= (sc + 1 == dat);
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_reset(input string nm);
        logic [9:0] f;
        f = {busy[0], done[0], err[0], wen[0], |ard[0], |awr[0], |dwr[0],
             sar[0], |xo[0], |wo[0]};
        chk(nm, longint'(f), longint'(10'b0000000100));
    endtask

    task automatic set_w(input int wsel);
        for (int i = 0; i < NK; i++) begin
            case (wsel)
                0: wts[i] = 1;
                1: wts[i] = -1;
                default: wts[i] = (i * 7) % 9 - 4;
            endcase
        end
    endtask

    task automatic run_case(input vec_t v);
        int dc, d0, xb0, bad, exp, idx;
        int w0[3], o0[3];
        bit bok;
        logic [DW*NK-1:0] ew;
        set_w(v.wsel);
        ny  = v.ny;
        dat = v.dat;
        run_id++;
        for (int d = 0; d < 3; d++) begin
            w0[d] = wrn[d];
            o0[d] = oob[d];
        end
        d0  = dcnt;
        xb0 = xbad;
        dc  = -1;
        bok = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start accepted busy/err", {busy[0], err[0]}, 2'b10);
        for (int c = 1; c < 450; c++) begin
            @(negedge clk);
            start = v.glitch && (c == 60 || c == 160);
            if (busy[0] !== 1'b1) bok = 1'b0;
            if (done[0] === 1'b1) begin
                dc = c;
                break;
            end
        end
        start = 1'b0;
        chk("done cycle", dc, v.xdone);
        chk("busy whole run", bok, 1);
        chk("err at done", err[0], v.xerr);
        @(negedge clk);
        chk("after done busy/done", {busy[0], done[0]}, 2'b00);
        repeat (5) @(negedge clk);
        chk("single done pulse", dcnt - d0, 1);
        chk("err sticky", err[0], v.xerr);
        for (int d = 0; d < 3; d++) begin
            bad = 0;
            for (int m = 0; m < M; m++) begin
                for (int k = 0; k < K; k++) begin
                    idx = (d == 1) ? m * K + k : k * M + m;
                    exp = gold(m, k, v.ny);
                    if (d == 2 && exp < 0) exp = 0;
                    if (tg[d][idx] != run_id || om[d][idx] !== 32'(exp)) bad++;
                end
            end
            chk($sformatf("mem words dut%0d", d), bad, 0);
            chk($sformatf("write count dut%0d", d), wrn[d] - w0[d], MK);
            chk($sformatf("out of range dut%0d", d), oob[d] - o0[d], 0);
        end
        for (int i = 0; i < NK; i++) ew[i*DW +: DW] = 32'(wts[i]);
        bad = 0;
        for (int i = 0; i < NK; i++)
            if (wo[0][i*DW +: DW] !== ew[i*DW +: DW]) bad++;
        chk("W lanes retained", bad, 0);
        chk("X zero after last row", xbad - xb0, 0);
    endtask

    initial begin
        int w0;
        rst   = 1'b0;
        start = 1'b0;
        for (int i = 0; i < MN; i++) img[i] = (i % 12) + 1;
        tbl[0] = '{wsel: 0, ny: 12, dat: 13, glitch: 0, xerr: 0, xdone: 231};
        tbl[1] = '{wsel: 1, ny: 12, dat: 13, glitch: 0, xerr: 0, xdone: 231};
        tbl[2] = '{wsel: 2, ny: 12, dat: 15, glitch: 0, xerr: 0, xdone: 233};
        tbl[3] = '{wsel: 0, ny: 10, dat: 12, glitch: 0, xerr: 1, xdone: 230};
        tbl[4] = '{wsel: 2, ny: 14, dat: 16, glitch: 0, xerr: 0, xdone: 234};
        tbl[5] = '{wsel: 0, ny: 12, dat: 13, glitch: 1, xerr: 0, xdone: 231};
        repeat (3) @(negedge clk);
        chk_reset("reset state");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset("idle after reset");

        for (int i = 0; i < 6; i++) run_case(tbl[i]);

        set_w(0);
        ny  = 12;
        dat = 13;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (165) @(negedge clk);
        chk("mid stream sa_rst low", sar[0], 0);
        w0  = wrn[0];
        rst = 1'b0;
        #1;
        chk_reset("reset mid stream");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (300) @(negedge clk);
        chk("no writes after abort", wrn[0] - w0, 0);
        chk("idle after abort busy", busy[0], 0);

        run_case(tbl[0]);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
